// File: rtl/lfsr_pkg.sv
// Shared types and the parametric Galois LFSR advance used by the PRBS engine.
package lfsr_pkg;

    localparam logic [31:0] TAPS_32_STD = 32'h0040_0007;
    localparam int unsigned LFSR_MAX_W  = 64;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } chk_state_t;

    // Applies 'steps' single-bit Galois shifts to the low 'width' bits of 'state'.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_adv(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width,
        input int unsigned           steps
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] top;
        logic [LFSR_MAX_W-1:0] s;
        logic                  msb;
        mask = ~({LFSR_MAX_W{1'b1}} << width);
        top  = mask & ~(mask >> 1);
        s    = state & mask;
        for (int unsigned i = 0; i < LFSR_MAX_W; i++) begin
            if (i < steps) begin
                msb = |(s & top);
                s   = ((s << 1) ^ (msb ? taps : '0)) & mask;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr_adv_comb.sv
// Combinational STEPS-fold advance of a WIDTH-bit Galois LFSR state.
module lfsr_adv_comb
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH = 32,
    parameter logic [WIDTH-1:0]  TAPS  = TAPS_32_STD,
    parameter int unsigned       STEPS = 1
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [LFSR_MAX_W-1:0] TAPS_X = LFSR_MAX_W'(TAPS);

    logic [LFSR_MAX_W-1:0] adv_full;
    logic                  unused_hi;

    assign adv_full  = lfsr_adv(LFSR_MAX_W'(cur), TAPS_X, WIDTH, STEPS);
    assign nxt       = adv_full[WIDTH-1:0];
    // Upper bits are masked to zero by the function; fold them away.
    assign unused_hi = ^adv_full;

endmodule

// File: rtl/lfsr_prbs_engine.sv
// PRBS engine: ready/valid generator (Mode=0) and self-synchronising checker (Mode=1)
// sharing one LFSR state register and one advance network.
module lfsr_prbs_engine
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_32_STD,
    parameter int unsigned      STEPS        = 1,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int unsigned      LOCK_CNT     = 8,
    parameter int unsigned      UNLOCK_CNT   = 4,
    parameter int unsigned      ERR_CNT_W    = 16
) (
    input  logic                 Clk,
    input  logic                 ARst,
    input  logic                 Mode,
    input  logic                 Enable,
    input  logic                 Load,
    input  logic [WIDTH-1:0]     Seed,
    output logic                 Dout_Valid,
    input  logic                 Dout_Ready,
    output logic [WIDTH-1:0]     Dout,
    input  logic                 Din_Valid,
    input  logic [WIDTH-1:0]     Din,
    input  logic                 ClrErr,
    output logic                 Locked,
    output logic                 ErrPulse,
    output logic [ERR_CNT_W-1:0] ErrCount
);

    localparam int unsigned    MCW      = $clog2(LOCK_CNT + 1);
    localparam int unsigned    UCW      = $clog2(UNLOCK_CNT + 1);
    localparam logic [MCW-1:0] LOCK_V   = MCW'(LOCK_CNT);
    localparam logic [UCW-1:0] UNLOCK_V = UCW'(UNLOCK_CNT);

    logic [WIDTH-1:0]     state_q, state_d, adv_w;
    chk_state_t           chk_q, chk_d, chk_cur;
    logic [MCW-1:0]       match_q, match_d;
    logic [UCW-1:0]       mism_q, mism_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 pulse_q, pulse_d;
    logic                 dv_q, en_q;
    logic                 restart, hit;

    lfsr_adv_comb #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_adv (
        .cur (state_q),
        .nxt (adv_w)
    );

    function automatic logic [WIDTH-1:0] nz(input logic [WIDTH-1:0] v);
        return (v == '0) ? SEED_DEFAULT : v;
    endfunction

    assign restart = Enable & Mode & ~en_q;
    assign hit     = (Din == adv_w);

    always_comb begin
        state_d = state_q;
        chk_d   = chk_q;
        match_d = match_q;
        mism_d  = mism_q;
        pulse_d = 1'b0;
        err_d   = err_q;
        // A fresh enable in check mode behaves as if the FSM were already in SEARCH.
        chk_cur = restart ? SEARCH : chk_q;

        if (Enable && !Mode) begin
            if (Load) begin
                state_d = nz(Seed);
            end else if (dv_q && Dout_Ready) begin
                state_d = adv_w;
            end
        end

        if (Enable && Mode) begin
            chk_d = chk_cur;
            if (restart) begin
                match_d = '0;
                mism_d  = '0;
            end
            if (Din_Valid) begin
                unique case (chk_cur)
                    SEARCH: begin
                        state_d = nz(Din);
                        match_d = '0;
                        mism_d  = '0;
                        chk_d   = VERIFY;
                    end
                    VERIFY: begin
                        if (hit) begin
                            state_d = adv_w;
                            match_d = match_q + 1'b1;
                            if (match_d == LOCK_V) begin
                                chk_d  = LOCKED;
                                mism_d = '0;
                            end
                        end else begin
                            state_d = nz(Din);
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        state_d = adv_w;
                        if (!hit) begin
                            pulse_d = 1'b1;
                            mism_d  = mism_q + 1'b1;
                            if (mism_d == UNLOCK_V) begin
                                chk_d   = SEARCH;
                                match_d = '0;
                                mism_d  = '0;
                            end
                        end else begin
                            mism_d = '0;
                        end
                    end
                    default: chk_d = SEARCH;
                endcase
            end
        end

        if (ClrErr) begin
            err_d = '0;
        end else if (pulse_d && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            state_q <= SEED_DEFAULT;
            chk_q   <= SEARCH;
            match_q <= '0;
            mism_q  <= '0;
            err_q   <= '0;
            pulse_q <= 1'b0;
            dv_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            match_q <= match_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
            dv_q    <= Enable & ~Mode;
            en_q    <= Enable;
        end
    end

    assign Dout       = state_q;
    assign Dout_Valid = dv_q;
    assign Locked     = (chk_q == LOCKED);
    assign ErrPulse   = pulse_q;
    assign ErrCount   = err_q;

endmodule

// File: tb/tb_lfsr_prbs_engine.sv
// Bench for lfsr_prbs_engine: sequence-position model plus directed literal checks,
// three instances (reference, 2-bit error counter, STEPS=8) sharing one stimulus.
module tb_lfsr_prbs_engine;

    logic       Clk = 1'b0;
    logic       ARst = 1'b1;
    logic       Mode = 1'b0, Enable = 1'b0, Load = 1'b0, Dout_Ready = 1'b0;
    logic       Din_Valid = 1'b0, ClrErr = 1'b0;
    logic [7:0] Seed = '0, Din = '0;

    logic        dv_a, dv_s, dv_b, lk_a, lk_s, lk_b, ep_a, ep_s, ep_b;
    logic [7:0]  do_a, do_s, do_b;
    logic [15:0] ec_a, ec_b;
    logic [1:0]  ec_s;

    int unsigned n_chk = 0, n_fail = 0;
    bit          run_chk = 1'b0;

    always #5 Clk = ~Clk;

    lfsr_prbs_engine #(.WIDTH(8), .TAPS(8'h1D), .STEPS(1), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_CNT_W(16)) u_dut (
        .Clk(Clk), .ARst(ARst), .Mode(Mode), .Enable(Enable), .Load(Load), .Seed(Seed),
        .Dout_Valid(dv_a), .Dout_Ready(Dout_Ready), .Dout(do_a), .Din_Valid(Din_Valid), .Din(Din),
        .ClrErr(ClrErr), .Locked(lk_a), .ErrPulse(ep_a), .ErrCount(ec_a));

    lfsr_prbs_engine #(.WIDTH(8), .TAPS(8'h1D), .STEPS(1), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_CNT_W(2)) u_sat (
        .Clk(Clk), .ARst(ARst), .Mode(Mode), .Enable(Enable), .Load(Load), .Seed(Seed),
        .Dout_Valid(dv_s), .Dout_Ready(Dout_Ready), .Dout(do_s), .Din_Valid(Din_Valid), .Din(Din),
        .ClrErr(ClrErr), .Locked(lk_s), .ErrPulse(ep_s), .ErrCount(ec_s));

    lfsr_prbs_engine #(.WIDTH(8), .TAPS(8'h1D), .STEPS(8), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_CNT_W(16)) u_s8 (
        .Clk(Clk), .ARst(ARst), .Mode(Mode), .Enable(Enable), .Load(Load), .Seed(Seed),
        .Dout_Valid(dv_b), .Dout_Ready(Dout_Ready), .Dout(do_b), .Din_Valid(Din_Valid), .Din(Din),
        .ClrErr(ClrErr), .Locked(lk_b), .ErrPulse(ep_b), .ErrCount(ec_b));

    // seq[k] = x^k mod (x^8+x^4+x^3+x^2+1); pos is its inverse. The model tracks positions.
    logic [7:0] seq [256];
    logic [7:0] pos [256];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] addm(input logic [7:0] i, input int unsigned n);
        int unsigned t;
        t = (32'(i) + n) % 255;
        return 8'(t);
    endfunction

    function automatic logic [7:0] nzb(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : v;
    endfunction

    logic [7:0]  m_k = '0, m_kb = '0, m_e;
    int unsigned m_fsm = 0, m_match = 0, m_mism = 0, m_ca = 0, m_cs = 0;
    bit          m_b_ok = 1'b1, m_dv = 1'b0, m_en_d = 1'b0, m_pulse = 1'b0, m_hit;

    always @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            m_k = '0; m_kb = '0; m_b_ok = 1'b1; m_dv = 1'b0; m_en_d = 1'b0;
            m_fsm = 0; m_match = 0; m_mism = 0; m_pulse = 1'b0; m_ca = 0; m_cs = 0;
        end else begin
            m_pulse = 1'b0;
            if (Enable && !Mode) begin
                if (Load) begin
                    m_k = pos[nzb(Seed)]; m_kb = m_k; m_b_ok = 1'b1;
                end else if (m_dv && Dout_Ready) begin
                    m_k = addm(m_k, 1); m_kb = addm(m_kb, 8);
                end
            end
            if (Enable && Mode) begin
                m_b_ok = 1'b0;
                if (!m_en_d) begin m_fsm = 0; m_match = 0; m_mism = 0; end
                if (Din_Valid) begin
                    m_e   = addm(m_k, 1);
                    m_hit = (seq[m_e] == Din);
                    if (m_fsm == 0) begin
                        m_k = pos[nzb(Din)]; m_match = 0; m_fsm = 1;
                    end else if (m_fsm == 1) begin
                        if (m_hit) begin
                            m_k = m_e; m_match++;
                            if (m_match == 4) m_fsm = 2;
                        end else begin
                            m_k = pos[nzb(Din)]; m_match = 0;
                        end
                    end else begin
                        m_k = m_e;
                        if (!m_hit) begin
                            m_pulse = 1'b1; m_mism++;
                            if (m_mism == 3) begin m_fsm = 0; m_match = 0; m_mism = 0; end
                        end else begin
                            m_mism = 0;
                        end
                    end
                end
            end
            if (ClrErr) begin
                m_ca = 0; m_cs = 0;
            end else if (m_pulse) begin
                if (m_ca < 65535) m_ca++;
                if (m_cs < 3) m_cs++;
            end
            m_dv   = Enable && !Mode;
            m_en_d = Enable;
        end
    end

    always @(negedge Clk) begin
        if (run_chk) begin
            check("dout",        32'(do_a), 32'(seq[m_k]));
            check("dout_valid",  32'(dv_a), 32'(m_dv));
            check("locked",      32'(lk_a), 32'(m_fsm == 2));
            check("err_pulse",   32'(ep_a), 32'(m_pulse));
            check("err_count",   32'(ec_a), m_ca);
            check("sat_locked",  32'(lk_s), 32'(m_fsm == 2));
            check("sat_count",   32'(ec_s), m_cs);
            if (m_b_ok) check("s8_dout", 32'(do_b), 32'(seq[m_kb]));
        end
    end

    logic [7:0] gl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
    logic [7:0] cl [5]  = '{8'h80, 8'h1D, 8'h3A, 8'h74, 8'hE8};
    logic [7:0] lw [5]  = '{8'hCD, 8'h86, 8'h13, 8'h26, 8'h4C};
    logic [7:0] bw [3]  = '{8'h99, 8'h2C, 8'h5B};

    initial begin
        logic [8:0] v;
        logic [7:0] p;
        v = 9'h001;
        for (int unsigned k = 0; k < 255; k++) begin
            seq[8'(k)] = v[7:0];
            pos[v[7:0]] = 8'(k);
            v = {v[7:0], 1'b0};
            if (v[8]) v = v ^ 9'h11D;
        end
        seq[255] = 8'h01;
        pos[0]   = 8'h00;

        repeat (2) @(negedge Clk);
        check("rst_dout",   32'(do_a), 32'h01);
        check("rst_dv",     32'(dv_a), 32'h0);
        check("rst_locked", 32'(lk_a), 32'h0);
        check("rst_count",  32'(ec_a), 32'h0);
        ARst = 1'b0; run_chk = 1'b1;

        Mode = 1'b0; Enable = 1'b1; Load = 1'b1; Seed = 8'h01; Dout_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            Load = 1'b0;
            check("gen_seq", 32'(do_a), 32'(gl[i]));
            if (i == 1) check("s8_seq1", 32'(do_b), 32'h1D);
            if (i == 2) check("s8_seq2", 32'(do_b), 32'h4C);
        end
        repeat (245) @(negedge Clk);
        check("gen_last", 32'(do_a), 32'h8E);
        @(negedge Clk);
        check("gen_period", 32'(do_a), 32'h01);
        check("s8_period",  32'(do_b), 32'h01);

        Seed = 8'h00; Load = 1'b1; Dout_Ready = 1'b0;
        @(negedge Clk); check("zero_seed", 32'(do_a), 32'h01); Load = 1'b0; Dout_Ready = 1'b1;
        @(negedge Clk); check("stall_a",   32'(do_a), 32'h02); Dout_Ready = 1'b0;
        @(negedge Clk); check("stall_b",   32'(do_a), 32'h02);
        @(negedge Clk); check("stall_c",   32'(do_a), 32'h02); Dout_Ready = 1'b1;
        @(negedge Clk); check("stall_end", 32'(do_a), 32'h04); Seed = 8'h80; Load = 1'b1;
        @(negedge Clk); check("load_prio", 32'(do_a), 32'h80); Load = 1'b0;
        @(negedge Clk); check("load_next", 32'(do_a), 32'h1D); Enable = 1'b0; Mode = 1'b1;
        @(negedge Clk); Enable = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 5; i++) begin
            Din = cl[i]; Din_Valid = 1'b1;
            @(negedge Clk);
            if (i == 3) check("lock_early", 32'(lk_a), 32'h0);
        end
        check("lock_5th", 32'(lk_a), 32'h1);
        check("lock_cnt", 32'(ec_a), 32'h0);

        for (int i = 0; i < 5; i++) begin
            Din = lw[i];
            @(negedge Clk);
            if (i == 1) begin
                check("err1_pulse",  32'(ep_a), 32'h1);
                check("err1_count",  32'(ec_a), 32'h1);
                check("err1_locked", 32'(lk_a), 32'h1);
            end
            if (i == 2) check("err1_clear", 32'(ep_a), 32'h0);
        end
        check("err1_hold", 32'(ec_a), 32'h1);
        Din_Valid = 1'b0; ClrErr = 1'b1;
        @(negedge Clk); ClrErr = 1'b0; check("clr_count", 32'(ec_a), 32'h0);

        Din_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Din = bw[i];
            @(negedge Clk);
            if (i == 1) check("bad2_locked", 32'(lk_a), 32'h1);
        end
        check("bad3_count",  32'(ec_a), 32'h3);
        check("bad3_sat",    32'(ec_s), 32'h3);
        check("bad3_locked", 32'(lk_a), 32'h0);

        p = 8'd100;
        for (int i = 0; i < 5; i++) begin
            Din = seq[p]; p = addm(p, 1);
            @(negedge Clk);
            if (i == 3) check("relock_early", 32'(lk_a), 32'h0);
        end
        check("relock", 32'(lk_a), 32'h1);
        Din_Valid = 1'b0; ClrErr = 1'b1;
        @(negedge Clk); ClrErr = 1'b0; Din_Valid = 1'b1;

        for (int j = 0; j < 9; j++) begin
            Din = (j % 2 == 0) ? (seq[p] ^ 8'h01) : seq[p];
            p = addm(p, 1);
            @(negedge Clk);
        end
        check("five_count",  32'(ec_a), 32'h5);
        check("five_sat",    32'(ec_s), 32'h3);
        check("five_locked", 32'(lk_a), 32'h1);

        Din = seq[p] ^ 8'h01; p = addm(p, 1); ClrErr = 1'b1;
        @(negedge Clk);
        ClrErr = 1'b0; Din_Valid = 1'b0;
        check("clrwin_pulse", 32'(ep_a), 32'h1);
        check("clrwin_count", 32'(ec_a), 32'h0);
        check("clrwin_sat",   32'(ec_s), 32'h0);
        check("pre_rst_lock", 32'(lk_a), 32'h1);

        #2 ARst = 1'b1;
        #1;
        check("arst_locked", 32'(lk_a), 32'h0);
        check("arst_dout",   32'(do_a), 32'h01);
        check("arst_dv",     32'(dv_a), 32'h0);
        @(negedge Clk); ARst = 1'b0; Enable = 1'b0;
        @(negedge Clk); Mode = 1'b0; Enable = 1'b1; Dout_Ready = 1'b1;
        @(negedge Clk);
        check("resume_dv",   32'(dv_a), 32'h1);
        check("resume_dout", 32'(do_a), 32'h01);
        @(negedge Clk);
        check("resume_next", 32'(do_a), 32'h02);
        check("resume_s8",   32'(do_b), 32'h1D);

        run_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
